// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
// The optional bne support is selected with the MC_BNE_EN macro.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    ANDIEX  = 4'd11,
    IMMWB   = 4'd12,
    JUMP    = 4'd13
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;

  // Moore control word; pcwrite and branch are combined into pcen by the top.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational decode of the controller state into the Moore control word.
import mc_pkg::*;

module mc_outdec (
  input  statetype_t i_state,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.alusrcb = 2'b01;
        o_ctrl.aluop   = ALUOP_ADD;
        o_ctrl.irwrite = 1'b1;
        o_ctrl.pcwrite = 1'b1;
      end
      DECODE: begin
        o_ctrl.alusrcb = 2'b11;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        o_ctrl.iord = 1'b1;
      end
      MEMWB: begin
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b00;
        o_ctrl.aluop   = ALUOP_RTYPE;
      end
      ALUWB: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b00;
        o_ctrl.aluop   = ALUOP_SUB;
        o_ctrl.pcsrc   = 2'b01;
        o_ctrl.branch  = 1'b1;
      end
      ADDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_ADD;
      end
      ORIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_OR;
      end
      ANDIEX: begin
        o_ctrl.alusrca = 1'b1;
        o_ctrl.alusrcb = 2'b10;
        o_ctrl.aluop   = ALUOP_AND;
      end
      IMMWB: begin
        o_ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        o_ctrl.pcsrc   = 2'b10;
        o_ctrl.pcwrite = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM with a retired-instruction counter.
// Define MC_BNE_EN to accept bne (op 000101); otherwise it is treated as illegal.
import mc_pkg::*;

module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  output logic             pcen,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             iord,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       pcsrc,
  output logic [2:0]       aluop,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  statetype_t       r_state;
  statetype_t       w_next;
  logic             w_illegal;
  logic             w_taken;
  logic             w_retire;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  ctrl_t            w_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = FETCH;
    w_illegal = 1'b0;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       w_next = BRANCH;
`endif
          OP_ADDI:      w_next = ADDIEX;
          OP_ORI:       w_next = ORIEX;
          OP_ANDI:      w_next = ANDIEX;
          OP_J:         w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   w_next = MEMWB;
      EXECUTE: w_next = ALUWB;
      ADDIEX, ORIEX, ANDIEX: w_next = IMMWB;
      default: w_next = FETCH;
    endcase
  end

`ifdef MC_BNE_EN
  logic r_bne;

  // The IR is not rewritten until FETCH, so the flag from DECODE stays valid in BRANCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_bne <= 1'b0;
    else if (r_state == DECODE) r_bne <= (op == OP_BNE);
  end

  assign w_taken = r_bne ? ~zero : zero;
`else
  assign w_taken = zero;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_illegal <= 1'b0;
    else       r_illegal <= (r_state == DECODE) && w_illegal;
  end

  // Terminal states always return to FETCH, so retiring is a function of state alone.
  assign w_retire = (r_state == MEMWB) || (r_state == MEMWR) || (r_state == ALUWB) ||
                    (r_state == IMMWB) || (r_state == BRANCH) || (r_state == JUMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_count <= '0;
    else if (w_retire) r_count <= r_count + CNT_W'(1);
  end

  mc_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign pcen        = ~reset & (w_ctrl.pcwrite | (w_ctrl.branch & w_taken));
  assign irwrite     = ~reset & w_ctrl.irwrite;
  assign memwrite    = ~reset & w_ctrl.memwrite;
  assign regwrite    = ~reset & w_ctrl.regwrite;
  assign iord        = w_ctrl.iord;
  assign alusrca     = w_ctrl.alusrca;
  assign alusrcb     = w_ctrl.alusrcb;
  assign memtoreg    = w_ctrl.memtoreg;
  assign regdst      = w_ctrl.regdst;
  assign pcsrc       = w_ctrl.pcsrc;
  assign aluop       = w_ctrl.aluop;
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule
